// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU slice: default widths, sequencer
// state encoding and ALU opcode constants.
package uart_alu_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_OP = 3'd1,
        WAIT_B  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } seq_state_e;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte timeout counter: counts while i_run is high, restarts on
// i_clear or when idle, and flags the terminal cycle on o_expired.
module uart_alu_timeout
    import uart_alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned      CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]    LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A received byte in the terminal cycle suppresses the expiry.
    assign o_expired = i_run && !i_clear && (cnt_q == LAST);

    // Next count: hold at zero outside the wait states, restart on clear/expiry.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!i_run || i_clear || o_expired) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: collects A, opcode, B from the UART receiver, lets the
// ALU settle for one cycle, captures the result and starts the transmitter.
// Optional inter-byte timeout is enabled by defining TIMEOUT_EN.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DEF,
    parameter int unsigned NB_OP          = NB_OP_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_rx_drop
);

    seq_state_e         state_q, state_d;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               rx_drop_q, rx_drop_d;
    logic               timeout;

`ifdef TIMEOUT_EN
    uart_alu_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_run     ((state_q == WAIT_OP) || (state_q == WAIT_B)),
        .i_clear   (i_rx_done),
        .o_expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    // Next-state and register-update logic for the frame FSM.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rx_drop_d  = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = WAIT_B;
                end else if (timeout) begin
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    rx_drop_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = EXEC;
                end else if (timeout) begin
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    rx_drop_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            EXEC: begin
                // Start pulse is registered so it coincides with SEND.
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                rx_drop_d  = i_rx_done;
                state_d    = SEND;
            end
            SEND: begin
                rx_drop_d = i_rx_done;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                rx_drop_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_rx_drop  = rx_drop_q;
    assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Testbench for uart_alu_sequencer: scoreboard of expected result bytes,
// bench-side ALU model, timeout expectations follow TIMEOUT_EN.
module tb_uart_alu_sequencer;
    import uart_alu_pkg::*;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rx_done = 1'b0;
    logic [NB_DATA-1:0] rx_data = '0;
    logic [NB_DATA-1:0] alu_a, alu_b, alu_res, tx_data;
    logic [NB_OP-1:0]   alu_op;
    logic               tx_start, tx_done = 1'b0, busy, rx_drop;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned drop_cnt = 0;
    int unsigned drop_base;
    logic        prev_start = 1'b0;
    logic [NB_DATA-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_res), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .i_tx_done(tx_done), .o_busy(busy), .o_rx_drop(rx_drop)
    );

    function automatic logic [NB_DATA-1:0] alu_model(input logic [NB_DATA-1:0] a,
                                                     input logic [NB_OP-1:0] op,
                                                     input logic [NB_DATA-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return $signed(a) >>> b;
            OP_SRL:  return a >> b;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_res = alu_model(alu_a, alu_op, alu_b);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every start pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_start_width", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 32'd1, 32'd0);
            end else begin
                check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_start = tx_start;
        if (rx_drop) drop_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_rx(input logic [NB_DATA-1:0] d);
        @(posedge clk); #1;
        rx_done = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_done = 1'b0; rx_data = '0;
    endtask

    task automatic pulse_tx_done();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    // Drives a full frame and stops in SEND with the start pulse visible.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] opb, input logic [7:0] b);
        logic [NB_OP-1:0] op;
        op = opb[NB_OP-1:0];
        pulse_rx(a);
        check("alu_a", 32'(alu_a), 32'(a));
        pulse_rx(opb);
        check("alu_op", 32'(alu_op), 32'(op));
        exp_q.push_back(alu_model(a, op, b));
        pulse_rx(b);
        check("alu_b", 32'(alu_b), 32'(b));
        check("busy_exec", 32'(busy), 32'd1);
        check("start_early", 32'(tx_start), 32'd0);
        tick();
        check("start_latency", 32'(tx_start), 32'd1);
    endtask

    task automatic finish_tx();
        tick(); tick();
        check("busy_wait_tx", 32'(busy), 32'd1);
        pulse_tx_done();
        check("busy_idle", 32'(busy), 32'd0);
        check("state_idle", 32'(dut.state_q), 32'(WAIT_A));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_op", 32'(alu_op), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(rx_drop), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic ADD, overflow wrap, SUB with upper opcode bits set, XOR
        send_frame(8'h53, 8'h20, 8'h01);
        finish_tx();
        send_frame(8'hFF, 8'h20, 8'h02);
        finish_tx();
        send_frame(8'h10, 8'hE2, 8'h03);
        finish_tx();
        send_frame(8'hA5, 8'h26, 8'h3C);
        finish_tx();

        // tx_done outside WAIT_TX is ignored
        pulse_rx(8'h21);
        pulse_tx_done();
        check("txdone_ignored", 32'(dut.state_q), 32'(WAIT_OP));
        pulse_rx(8'h20);
        exp_q.push_back(8'h22);
        pulse_rx(8'h01);
        tick();
        check("start_after_ignore", 32'(tx_start), 32'd1);
        finish_tx();

        // Byte while waiting for the transmitter is dropped
        send_frame(8'h40, 8'h20, 8'h01);
        drop_base = drop_cnt;
        pulse_rx(8'h11);
        tick();
        check("drop_wait_tx", drop_cnt - drop_base, 32'd1);
        check("a_kept_on_drop", 32'(alu_a), 32'h40);
        finish_tx();
        send_frame(8'h05, 8'h20, 8'h03);
        finish_tx();

        // Reset mid-frame clears partial operands
        pulse_rx(8'h53);
        pulse_rx(8'h20);
        rst_n = 1'b0;
        repeat (3) tick();
        check("mid_rst_a", 32'(alu_a), 32'd0);
        check("mid_rst_op", 32'(alu_op), 32'd0);
        check("mid_rst_txd", 32'(tx_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        send_frame(8'h02, 8'h20, 8'h02);
        finish_tx();

        // Reset landing in SEND kills the start pulse at once
        pulse_rx(8'h09);
        pulse_rx(8'h20);
        pulse_rx(8'h09);
        tick();
        rst_n = 1'b0;
        #1;
        check("start_async_rst", 32'(tx_start), 32'd0);
        check("busy_async_rst", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        send_frame(8'h07, 8'h20, 8'h02);
        finish_tx();

        // Inter-byte timeout
        drop_base = drop_cnt;
        pulse_rx(8'h53);
        repeat (100) @(posedge clk);
        #1;
`ifdef TIMEOUT_EN
        check("to_state", 32'(dut.state_q), 32'(WAIT_A));
        check("to_a_clr", 32'(alu_a), 32'd0);
        check("to_b_clr", 32'(alu_b), 32'd0);
        check("to_op_kept", 32'(alu_op), 32'h20);
        tick();
        check("to_drop", drop_cnt - drop_base, 32'd1);
        send_frame(8'h30, 8'h20, 8'h04);
        finish_tx();
`else
        check("to_state", 32'(dut.state_q), 32'(WAIT_OP));
        check("to_a_kept", 32'(alu_a), 32'h53);
        tick();
        check("to_nodrop", drop_cnt - drop_base, 32'd0);
        pulse_rx(8'h20);
        exp_q.push_back(8'h54);
        pulse_rx(8'h01);
        tick();
        check("start_after_idle", 32'(tx_start), 32'd1);
        finish_tx();
`endif

        // Same-cycle tx_done and rx_done in WAIT_TX
        send_frame(8'h07, 8'h20, 8'h01);
        drop_base = drop_cnt;
        tick();
        rx_done = 1'b1; rx_data = 8'h99; tx_done = 1'b1;
        tick();
        rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
        check("same_state", 32'(dut.state_q), 32'(WAIT_A));
        check("same_a_kept", 32'(alu_a), 32'h07);
        tick();
        check("same_drop", drop_cnt - drop_base, 32'd1);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
